// File: rtl/dtcm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_ctrl_if
// Desc     : LSU command/response handshake bundle for the DTCM controller.
// Revision : 1.0
// ============================================================================
interface dtcm_ctrl_if;
    logic        lsu_cmd_valid;
    logic        lsu_cmd_ready;
    logic        lsu_cmd_read;
    logic [31:0] lsu_cmd_addr;
    logic [1:0]  lsu_cmd_size;
    logic        lsu_cmd_usign;
    logic [31:0] lsu_cmd_wdata;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;

    modport master (
        output lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_size,
               lsu_cmd_usign, lsu_cmd_wdata, lsu_rsp_ready,
        input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err
    );

    modport slave (
        input  lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_size,
               lsu_cmd_usign, lsu_cmd_wdata, lsu_rsp_ready,
        output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dtcm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_ctrl
// Desc     : LSU-facing DTCM controller: byte/half/word load-store with
//            write-mask generation and aligned, extended load responses.
//            Optional misalignment check: define DTCM_MISALIGN_CHK_EN.
// Revision : 1.0
// ============================================================================
module dtcm_ctrl #(
    parameter int RAM_AW = 14,
    parameter int DW     = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    dtcm_ctrl_if.slave             lsu,
    output logic                   ram_we,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic [DW-1:0]          ram_din,
    output logic [DW/8-1:0]        ram_wem,
    input  wire logic [DW-1:0]     ram_dout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [1:0]    w_cmd_dst;
    logic          w_fire;
    logic          w_rsp_hs;
    logic          w_mis;

    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_usign;
    logic [DW-1:0] r_rdata;
    logic [1:0]    w_sh;
    logic [DW-1:0] w_lane;
    logic [DW-1:0] w_fmt;

    wire w_unused = &{1'b0, lsu.lsu_cmd_addr[31:RAM_AW+2]};

    assign lsu.lsu_cmd_ready = (r_state == S_IDLE) |
                               ((r_state == S_RSP) & lsu.lsu_rsp_ready);
    assign lsu.lsu_rsp_valid = (r_state == S_RSP);
    assign lsu.lsu_rsp_rdata = r_rdata;

    assign w_fire   = lsu.lsu_cmd_valid & lsu.lsu_cmd_ready;
    assign w_rsp_hs = (r_state == S_RSP) & lsu.lsu_rsp_ready;
    assign ram_addr = lsu.lsu_cmd_addr[RAM_AW+1:2];

`ifdef DTCM_MISALIGN_CHK_EN
    assign w_mis = ((lsu.lsu_cmd_size == 2'd1) & lsu.lsu_cmd_addr[0]) |
                   (lsu.lsu_cmd_size[1] & (|lsu.lsu_cmd_addr[1:0]));
`else
    assign w_mis = 1'b0;
`endif

    // Misaligned loads skip the RAM read and answer straight away.
    assign w_cmd_dst = (lsu.lsu_cmd_read & ~w_mis) ? S_RD : S_RSP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_state_nxt = w_cmd_dst;
            S_RD:    w_state_nxt = S_RSP;
            S_RSP:   if (w_rsp_hs) w_state_nxt = w_fire ? w_cmd_dst : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_we = w_fire & ~lsu.lsu_cmd_read & ~w_mis;
        case (lsu.lsu_cmd_size)
            2'd0: begin
                ram_din = {4{lsu.lsu_cmd_wdata[7:0]}};
                ram_wem = 4'b0001 << lsu.lsu_cmd_addr[1:0];
            end
            2'd1: begin
                ram_din = {2{lsu.lsu_cmd_wdata[15:0]}};
                ram_wem = 4'b0011 << {lsu.lsu_cmd_addr[1], 1'b0};
            end
            default: begin
                ram_din = lsu.lsu_cmd_wdata;
                ram_wem = 4'b1111;
            end
        endcase
        if (!ram_we) ram_wem = 4'b0000;
    end

    // Lane shift mirrors the store mask: halves use addr[1], words no shift.
    always_comb begin
        case (r_size)
            2'd0:    w_sh = r_off;
            2'd1:    w_sh = {r_off[1], 1'b0};
            default: w_sh = 2'd0;
        endcase
        w_lane = ram_dout >> {w_sh, 3'b000};
        case (r_size)
            2'd0:    w_fmt = {{24{w_lane[7]  & ~r_usign}}, w_lane[7:0]};
            2'd1:    w_fmt = {{16{w_lane[15] & ~r_usign}}, w_lane[15:0]};
            default: w_fmt = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off   <= 2'd0;
            r_size  <= 2'd0;
            r_usign <= 1'b0;
            r_rdata <= '0;
        end else if (w_fire) begin
            r_off   <= lsu.lsu_cmd_addr[1:0];
            r_size  <= lsu.lsu_cmd_size;
            r_usign <= lsu.lsu_cmd_usign;
            r_rdata <= '0;
        end else if (r_state == S_RD) begin
            r_rdata <= w_fmt;
        end
    end

`ifdef DTCM_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_fire) begin
            r_err <= w_mis;
        end
    end

    assign lsu.lsu_rsp_err = r_err;
`else
    assign lsu.lsu_rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire
